diff_arbiter: RTL and testbench

Round-robin scheduler that shares a single lowest-differing-bit (diff) unit among `NREQ` requesters in the KGP RISC processor. Typical requesters are the ALU issue path and auxiliary units. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, computes `pos` (index of the least-significant bit where `a` and `b` differ, 32 if equal) and returns it tagged with the requester id under a valid/ready response handshake.

---
 rtl/diff_arbiter.sv | 98 +++++++++
 tb/tb_diff_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/diff_arbiter.sv
// diff_arbiter: round-robin arbiter sharing one lowest-differing-bit unit among NREQ requesters.
module diff_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_pos,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, a_sel, b_sel, x;
    logic [5:0] pos, rsp_pos_q, rsp_pos_d;
    logic rsp_valid_q, rsp_valid_d, found;
    int sel_idx, best;
    // The valid requester at the smallest upward distance from ptr_q wins.
    always_comb begin
        found = 1'b0;
        sel_idx = 0;
        best = NREQ;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && ((i + NREQ - int'(ptr_q)) % NREQ) < best) begin
                best = (i + NREQ - int'(ptr_q)) % NREQ;
                found = 1'b1;
                sel_idx = i;
                a_sel = req_a[32*i +: 32];
                b_sel = req_b[32*i +: 32];
            end
        end
    end
    always_comb begin
        x = op_a_q ^ op_b_q;
        pos = 6'd32;
        for (int i = 31; i >= 0; i--) if (x[i]) pos = 6'(i);
    end
    assign req_ready = (state_q == IDLE && found) ? NREQ'(1) << sel_idx : '0;
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        id_d = id_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        rsp_id_d = rsp_id_q;
        rsp_pos_d = rsp_pos_q;
        rsp_valid_d = rsp_valid_q;
        if (state_q == IDLE && found) begin
            state_d = CALC;
            ptr_d = IDW'((sel_idx + 1) % NREQ);
            id_d = IDW'(sel_idx);
            op_a_d = a_sel;
            op_b_d = b_sel;
        end else if (state_q == CALC) begin
            state_d = DONE;
            rsp_pos_d = pos;
            rsp_id_d = id_q;
            rsp_valid_d = 1'b1;
        end else if (state_q == DONE && rsp_ready) begin
            state_d = IDLE;
            rsp_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            id_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            rsp_id_q <= '0;
            rsp_pos_q <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            id_q <= id_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            rsp_id_q <= rsp_id_d;
            rsp_pos_q <= rsp_pos_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_pos = {26'd0, rsp_pos_q};
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_diff_arbiter.sv
// tb_diff_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_diff_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rsp_valid, rsp_ready, busy;
    logic [N-1:0] req_valid, req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic [1:0] rsp_id;
    logic [31:0] rsp_pos;
    diff_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_pos(rsp_pos), .busy(busy)
    );
    int n_total = 0, n_bad = 0, ncyc = 0;
    int m_ptr = 0, m_phase = 0, m_id = 0, m_pos = 0, last_g = -1;
    int grants[$], gcyc[$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int low_diff(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        if (x == 0) return 32;
        return $clog2(x & (~x + 32'd1));
    endfunction
    function automatic int rr_pick();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    // Model phases: 0 waiting for a grant, 1 computing, 2 result offered.
    task automatic cyc();
        int g;
        @(negedge clk);
        g = (m_phase == 0) ? rr_pick() : -1;
        chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        if (m_phase == 2) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_pos", rsp_pos, 32'(m_pos));
        end
        last_g = -1;
        if (rst) begin
            m_phase = 0;
            m_ptr = 0;
        end else if (m_phase == 0 && g >= 0) begin
            m_id = g;
            m_pos = low_diff(req_a[32*g +: 32], req_b[32*g +: 32]);
            m_ptr = (g + 1) % N;
            m_phase = 1;
            last_g = g;
            grants.push_back(g);
            gcyc.push_back(ncyc);
        end else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && rsp_ready) m_phase = 0;
        @(posedge clk);
        #1;
        ncyc++;
    endtask
    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask
    task automatic rand_op(input int i);
        logic [31:0] a;
        a = $urandom;
        case ($urandom % 4)
            0: set_op(i, a, a);
            1: set_op(i, a, a ^ (32'd1 << $urandom_range(31, 0)));
            2: set_op(i, a, a ^ ($urandom << $urandom_range(31, 0)));
            default: set_op(i, a, $urandom);
        endcase
    endtask
    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cyc();
    endtask
    task automatic one(input int i, input logic [31:0] a, input logic [31:0] b, input int pos);
        set_op(i, a, b);
        req_valid[i] = 1'b1;
        rsp_ready = 1'b1;
        cyc();
        req_valid[i] = 1'b0;
        cyc();
        chk("one_valid", 32'(rsp_valid), 32'd1);
        chk("one_pos", rsp_pos, 32'(pos));
        chk("one_id", 32'(rsp_id), 32'(i));
        cyc();
    endtask
    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_pos", rsp_pos, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        one(0, 32'h0000_0010, 32'h0, 4);
        one(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32);
        one(2, 32'h8000_0000, 32'h0, 31);
        one(3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        // All requesters valid from reset: strict rotation every 3 cycles.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) rand_op(i);
        grants.delete();
        gcyc.delete();
        req_valid = '1;
        repeat (13) cyc();
        chk("rr_count", grants.size(), 5);
        for (int k = 0; k < grants.size() && k < 5; k++) begin
            chk("rr_order", grants[k], k % N);
            if (k > 0) chk("rr_space", gcyc[k] - gcyc[k-1], 3);
        end
        // Backpressure in DONE with other requests pending.
        drain();
        set_op(2, 32'h100, 32'h0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        cyc();
        rand_op(0);
        rand_op(1);
        req_valid = 4'b0011;
        cyc();
        repeat (5) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_pos", rsp_pos, 32'd8);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_grant", 32'(req_ready), 32'b0001);
        // Reset during CALC: no response and pointer back to 0.
        drain();
        set_op(1, 32'h1, 32'h0);
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_valid", 32'(rsp_valid), 32'd0);
        repeat (3) begin
            chk("ra_norsp", 32'(rsp_valid), 32'd0);
            cyc();
        end
        rand_op(1);
        rand_op(2);
        req_valid = 4'b0110;
        cyc();
        chk("ra_ptr", grants[grants.size()-1], 1);
        // Fairness: requesters 1 and 3 with pointer at 2.
        drain();
        one(1, 32'h5, 32'h5, 32);
        rand_op(1);
        rand_op(3);
        grants.delete();
        req_valid = 4'b1010;
        repeat (12) cyc();
        chk("fair_count", grants.size(), 4);
        if (grants.size() >= 3) begin
            chk("fair_0", grants[0], 3);
            chk("fair_1", grants[1], 1);
            chk("fair_2", grants[2], 3);
        end
        // Random traffic with legal requester behaviour, backpressure and rare resets.
        drain();
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && last_g == i) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom % 4 == 0) begin
                    rand_op(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom % 32 == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom % 3) != 0;
            rst = ($urandom % 200) == 0;
            cyc();
        end
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
